// File: rtl/line_fill_unit_pkg.sv
// Shared constants and types for the line fill unit and the L1 cache that sits above it.
package line_fill_unit_pkg;

  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 13;
  localparam int ADDRESS_SIZE   = 64;
  localparam int LINE_BYTES     = 64;
  localparam int OFFSET_SIZE_B  = 6;
  localparam int BEATS          = LINE_BYTES * 8 / BUS_DATA_WIDTH;
  localparam int BEAT_IDX_W     = $clog2(BEATS);

  localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 13'h0001;
  localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 13'h0002;

  typedef logic [LINE_BYTES*8-1:0]   cache_line;
  typedef logic [ADDRESS_SIZE-1:0]   addr_t;
  typedef logic [BEAT_IDX_W-1:0]     beat_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    RD_DONE,
    WB_ADDR,
    WB_DATA
  } fill_state_t;

  function automatic addr_t alignLine(input addr_t a);
    return a & ~addr_t'((1 << OFFSET_SIZE_B) - 1);
  endfunction

endpackage

// File: rtl/line_fill_unit_if.sv
// Cache-side request/return and memory-bus signals of the line fill unit.
interface line_fill_unit_if;
  import line_fill_unit_pkg::*;

  logic                      fill_req;
  logic [ADDRESS_SIZE-1:0]   fill_addr;
  logic                      wb_req;
  logic [ADDRESS_SIZE-1:0]   wb_addr;
  logic [LINE_BYTES*8-1:0]   wb_line;
  logic                      ready;

  logic                      line_valid;
  logic [ADDRESS_SIZE-1:0]   line_addr;
  logic [LINE_BYTES*8-1:0]   line_data;

  logic                      bus_reqcyc;
  logic                      bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_respcyc;
  logic                      bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

  // The fill unit itself is the slave; the cache plus memory model is the master.
  modport slave (
    input  fill_req, fill_addr, wb_req, wb_addr, wb_line,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output ready, line_valid, line_addr, line_data,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output fill_req, fill_addr, wb_req, wb_addr, wb_line,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  ready, line_valid, line_addr, line_data,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

endinterface

// File: rtl/line_beat_buffer.sv
// 8 x 64-bit beat store: assembles read beats into a line, or holds a victim line
// that is serialized beat by beat during writeback.
module line_beat_buffer
  import line_fill_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wrEn_i,
  input  beat_idx_t                 wrIdx_i,
  input  logic [BUS_DATA_WIDTH-1:0] wrData_i,
  input  logic                      loadEn_i,
  input  cache_line                 loadLine_i,
  input  beat_idx_t                 rdIdx_i,
  output logic [BUS_DATA_WIDTH-1:0] rdData_o,
  output cache_line                 line_o
);

  logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] beats_q;

  // A whole-line load (victim capture) takes precedence over a single-beat write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats_q <= '0;
    end else if (loadEn_i) begin
      beats_q <= loadLine_i;
    end else if (wrEn_i) begin
      beats_q[wrIdx_i] <= wrData_i;
    end
  end

  assign rdData_o = beats_q[rdIdx_i];
  assign line_o   = beats_q;

endmodule

// File: rtl/line_fill_unit.sv
// Bus-side miss handler: runs one line fill or one dirty-line writeback at a time
// and returns assembled fill lines to the cache with a one-cycle valid pulse.
module line_fill_unit
  import line_fill_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  line_fill_unit_if.slave  lfu
);

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  fill_state_t               state_q, state_d;
  beat_idx_t                 cnt_q, cnt_d;
  addr_t                     addr_q, addr_d;
  logic                      reqcyc_q, reqcyc_d;
  logic [BUS_DATA_WIDTH-1:0] req_q, req_d;
  logic [BUS_TAG_WIDTH-1:0]  reqtag_q, reqtag_d;
  logic                      respack_q, respack_d;

  logic                      bufWrEn;
  logic                      bufLoadEn;
  beat_idx_t                 bufRdIdx;
  logic [BUS_DATA_WIDTH-1:0] bufRdData;
  cache_line                 bufLine;
  logic                      lineValid;

  // Read index looks one beat ahead so the next write beat is registered onto the bus on ack.
  assign bufRdIdx = (state_q == WB_DATA) ? beat_idx_t'(cnt_q + 1'b1) : '0;

  line_beat_buffer u_buf (
    .clk        (clk),
    .reset      (reset),
    .wrEn_i     (bufWrEn),
    .wrIdx_i    (cnt_q),
    .wrData_i   (lfu.bus_resp),
    .loadEn_i   (bufLoadEn),
    .loadLine_i (lfu.wb_line),
    .rdIdx_i    (bufRdIdx),
    .rdData_o   (bufRdData),
    .line_o     (bufLine)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      reqcyc_q  <= 1'b0;
      req_q     <= '0;
      reqtag_q  <= '0;
      respack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      reqcyc_q  <= reqcyc_d;
      req_q     <= req_d;
      reqtag_q  <= reqtag_d;
      respack_q <= respack_d;
    end
  end

  // Bus request outputs are computed for the coming cycle so they leave the unit registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    reqcyc_d  = 1'b0;
    req_d     = '0;
    reqtag_d  = '0;
    respack_d = 1'b0;
    bufWrEn   = 1'b0;
    bufLoadEn = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lfu.wb_req) begin
          state_d   = WB_ADDR;
          addr_d    = alignLine(lfu.wb_addr);
          bufLoadEn = 1'b1;
          reqcyc_d  = 1'b1;
          req_d     = alignLine(lfu.wb_addr);
          reqtag_d  = MEM_WRITE;
        end else if (lfu.fill_req) begin
          state_d  = RD_REQ;
          addr_d   = alignLine(lfu.fill_addr);
          reqcyc_d = 1'b1;
          req_d    = alignLine(lfu.fill_addr);
          reqtag_d = MEM_READ;
        end
      end

      RD_REQ: begin
        if (lfu.bus_reqack) begin
          state_d = RD_DATA;
          cnt_d   = '0;
        end else begin
          reqcyc_d = 1'b1;
          req_d    = req_q;
          reqtag_d = MEM_READ;
        end
      end

      RD_DATA: begin
        if (lfu.bus_respcyc && (lfu.bus_resptag == MEM_READ)) begin
          bufWrEn   = 1'b1;
          respack_d = 1'b1;
          cnt_d     = beat_idx_t'(cnt_q + 1'b1);
          if (cnt_q == LAST_BEAT) begin
            state_d = RD_DONE;
          end
        end
      end

      RD_DONE: begin
        state_d = IDLE;
      end

      WB_ADDR: begin
        reqcyc_d = 1'b1;
        reqtag_d = MEM_WRITE;
        if (lfu.bus_reqack) begin
          state_d = WB_DATA;
          cnt_d   = '0;
          req_d   = bufRdData;
        end else begin
          req_d = req_q;
        end
      end

      WB_DATA: begin
        if (lfu.bus_reqack) begin
          cnt_d = beat_idx_t'(cnt_q + 1'b1);
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            reqcyc_d = 1'b1;
            reqtag_d = MEM_WRITE;
            req_d    = bufRdData;
          end
        end else begin
          reqcyc_d = 1'b1;
          reqtag_d = MEM_WRITE;
          req_d    = req_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lineValid = (state_q == RD_DONE);

  // Line address/data are only presented alongside the valid pulse, never a captured victim.
  assign lfu.ready       = (state_q == IDLE);
  assign lfu.line_valid  = lineValid;
  assign lfu.line_addr   = lineValid ? addr_q : '0;
  assign lfu.line_data   = lineValid ? bufLine : '0;
  assign lfu.bus_reqcyc  = reqcyc_q;
  assign lfu.bus_req     = req_q;
  assign lfu.bus_reqtag  = reqtag_q;
  assign lfu.bus_respack = respack_q;

endmodule
